// File: rtl/interrupt_stimulus_driver.sv
// Programmable interrupt source: queued (mask, delay, hold) commands raise and release lines
// cycle-accurately. Define INTR_DRV_RANDOM_EN to add LFSR-driven random single-line pulses.
module interrupt_stimulus_driver #(
  parameter int ID    = 0,
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int DLY_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [DLY_W-1:0] cmd_delay,
  input  logic [DLY_W-1:0] cmd_hold,
  input  logic [WIDTH-1:0] ack,
`ifdef INTR_DRV_RANDOM_EN
  input  logic             rand_en,
`endif
  output logic [WIDTH-1:0] interrupts,
  output logic             busy,
  output logic             done_pulse
);

  localparam int AW = $clog2(DEPTH);

  if (WIDTH < 1 || WIDTH > 32 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ID < 0) begin : g_bad_param
    $error("interrupt_stimulus_driver: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ASSERT} state_t;

  logic [WIDTH-1:0] fifo_mask_q  [DEPTH];
  logic [DLY_W-1:0] fifo_delay_q [DEPTH];
  logic [DLY_W-1:0] fifo_hold_q  [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             fifo_full, fifo_empty, push, pop;

  state_t           state_q;
  logic [WIDTH-1:0] intr_q, mask_q, intr_acked_d;
  logic [DLY_W-1:0] hold_q, cnt_q;
  logic             done_q;

  assign fifo_full  = (count_q == (AW+1)'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;

  // Payload storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mask_q[wr_ptr_q]  <= cmd_mask;
      fifo_delay_q[wr_ptr_q] <= cmd_delay;
      fifo_hold_q[wr_ptr_q]  <= cmd_hold;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef INTR_DRV_RANDOM_EN
  localparam logic [15:0] SEED = 16'hACE1 ^ 16'(ID);
  logic [15:0]      lfsr_q;
  logic             rand_start;
  logic [WIDTH-1:0] rand_mask;
  logic [DLY_W-1:0] rand_hold;
  int               rand_idx;

  assign rand_idx   = int'(lfsr_q[8:4]) % WIDTH;
  assign rand_mask  = WIDTH'(1) << rand_idx;
  assign rand_hold  = DLY_W'({1'b0, lfsr_q[12:9]} + 5'd1);
  assign rand_start = rand_en && fifo_empty && (lfsr_q[3:0] == 4'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
`endif

  assign intr_acked_d = intr_q & ~ack;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      intr_q  <= '0;
      mask_q  <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            mask_q  <= fifo_mask_q[rd_ptr_q];
            hold_q  <= fifo_hold_q[rd_ptr_q];
            cnt_q   <= fifo_delay_q[rd_ptr_q];
            state_q <= S_WAIT;
          end
`ifdef INTR_DRV_RANDOM_EN
          else if (rand_start) begin
            mask_q  <= rand_mask;
            hold_q  <= rand_hold;
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
`endif
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            intr_q  <= intr_q | mask_q;
            cnt_q   <= hold_q;
            state_q <= S_ASSERT;
          end else begin
            cnt_q <= cnt_q - DLY_W'(1);
          end
        end
        S_ASSERT: begin
          // An empty mask must still honour a nonzero hold, so "all acked" needs a real mask.
          if (hold_q != '0 && cnt_q == DLY_W'(1)) begin
            intr_q  <= '0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else if (intr_q == '0 && (mask_q != '0 || hold_q == '0)) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            intr_q <= intr_acked_d;
            if (hold_q != '0) cnt_q <= cnt_q - DLY_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign interrupts = intr_q;
  assign done_pulse = done_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_interrupt_stimulus_driver.sv
// Directed bench for interrupt_stimulus_driver (WIDTH=4, DEPTH=4) in the default build.
module tb_interrupt_stimulus_driver;

  localparam int W = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [W-1:0]  cmd_mask;
  logic [15:0]   cmd_delay;
  logic [15:0]   cmd_hold;
  logic [W-1:0]  ack;
  logic [W-1:0]  interrupts;
  logic          busy;
  logic          done_pulse;

  int n_vec = 0;
  int n_bad = 0;

  interrupt_stimulus_driver #(.ID(0), .WIDTH(W), .DEPTH(4), .DLY_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mask   (cmd_mask),
    .cmd_delay  (cmd_delay),
    .cmd_hold   (cmd_hold),
    .ack        (ack),
    .interrupts (interrupts),
    .busy       (busy),
    .done_pulse (done_pulse)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offers one command for one cycle; returns in the cycle after the accepting edge.
  task automatic start_cmd(input logic [W-1:0] m, input logic [15:0] d, input logic [15:0] h);
    cmd_valid = 1'b1;
    cmd_mask  = m;
    cmd_delay = d;
    cmd_hold  = h;
    tick();
    cmd_valid = 1'b0;
  endtask

  // mask=1, delay=0, hold=3 pushed in cycle t: high t+3..t+5, done at t+6.
  task automatic single_cmd_test(input string pfx);
    start_cmd(4'b0001, 16'd0, 16'd3);
    check_eq({pfx, "_busy_t1"}, busy, 1);
    check_eq({pfx, "_intr_t1"}, interrupts, 0);
    tick();
    check_eq({pfx, "_intr_t2"}, interrupts, 0);
    for (int c = 3; c <= 5; c++) begin
      tick();
      check_eq({pfx, "_intr_hi"}, interrupts, 4'b0001);
      check_eq({pfx, "_done_hi"}, done_pulse, 0);
    end
    tick();
    check_eq({pfx, "_intr_t6"}, interrupts, 0);
    check_eq({pfx, "_done_t6"}, done_pulse, 1);
    tick();
    check_eq({pfx, "_done_t7"}, done_pulse, 0);
    check_eq({pfx, "_busy_t7"}, busy, 0);
  endtask

  function automatic logic [W-1:0] seq_exp(input int k);
    case (k)
      23:      return 4'b0011;
      26:      return 4'b0001;
      29:      return 4'b0010;
      32:      return 4'b0100;
      35:      return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  initial begin
    logic [W-1:0] exp_i;
    logic [W-1:0] push_masks [5];
    push_masks = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111};

    reset = 1'b1; cmd_valid = 1'b0; cmd_mask = '0; cmd_delay = '0; cmd_hold = '0; ack = '0;
    tick(); tick();
    check_eq("rst_intr",  interrupts, 0);
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_busy",  busy, 0);
    check_eq("rst_done",  done_pulse, 0);
    reset = 1'b0;
    tick();
    check_eq("post_rst_busy", busy, 0);

    single_cmd_test("basic");

    // mask 1010, delay 5, hold 0: high from t+8, acks in t+10 and t+13, stray ack on bit0.
    start_cmd(4'b1010, 16'd5, 16'd0);
    for (int c = 1; c <= 18; c++) begin
      if (c > 1) tick();
      ack   = (c == 10) ? 4'b0010 : (c == 13) ? 4'b1000 : (c == 9) ? 4'b0001 : 4'b0000;
      exp_i = (c < 8) ? 4'b0000 : (c <= 10) ? 4'b1010 : (c <= 13) ? 4'b1000 : 4'b0000;
      check_eq($sformatf("ack_intr_c%0d", c), interrupts, exp_i);
      check_eq($sformatf("ack_done_c%0d", c), done_pulse, (c == 15));
    end
    ack = '0;
    check_eq("ack_busy_end", busy, 0);

    // A long command keeps the FSM busy while the FIFO fills; the fifth offer is refused.
    start_cmd(4'b0011, 16'd20, 16'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_mask  = push_masks[i];
      cmd_delay = 16'd0;
      cmd_hold  = 16'd1;
      check_eq($sformatf("fill_ready_%0d", i), cmd_ready, (i < 4));
      tick();
    end
    cmd_valid = 1'b0;
    for (int k = 7; k <= 40; k++) begin
      check_eq($sformatf("seq_intr_k%0d", k), interrupts, seq_exp(k));
      check_eq($sformatf("seq_done_k%0d", k), done_pulse,
               (k == 24 || k == 27 || k == 30 || k == 33 || k == 36));
      if (k < 40) tick();
    end
    check_eq("seq_busy_end", busy, 0);

    // hold=2 with ack on the last held cycle: one retire only.
    start_cmd(4'b0100, 16'd0, 16'd2);
    tick();
    tick();
    check_eq("h2_intr_t3", interrupts, 4'b0100);
    tick();
    check_eq("h2_intr_t4", interrupts, 4'b0100);
    ack = 4'b0100;
    tick();
    ack = '0;
    check_eq("h2_intr_t5", interrupts, 0);
    check_eq("h2_done_t5", done_pulse, 1);
    tick();
    check_eq("h2_done_t6", done_pulse, 0);
    tick();
    check_eq("h2_done_t7", done_pulse, 0);

    // Empty mask, hold 0: retires one cycle after entering ASSERT (t+3), done at t+4.
    start_cmd(4'b0000, 16'd0, 16'd0);
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
      check_eq($sformatf("m0h0_done_c%0d", c), done_pulse, (c == 4));
    end

    // Empty mask, delay 2, hold 3: ASSERT t+5..t+7, done at t+8.
    start_cmd(4'b0000, 16'd2, 16'd3);
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) tick();
      check_eq($sformatf("m0h3_done_c%0d", c), done_pulse, (c == 8));
      check_eq($sformatf("m0h3_intr_c%0d", c), interrupts, 0);
    end

    // Async reset mid-ASSERT with two commands queued.
    start_cmd(4'b1111, 16'd0, 16'd0);
    cmd_valid = 1'b1; cmd_mask = 4'b0001; cmd_delay = 16'd0; cmd_hold = 16'd1;
    tick();
    cmd_mask = 4'b0010;
    tick();
    cmd_valid = 1'b0;
    check_eq("mid_intr", interrupts, 4'b1111);
    check_eq("mid_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_intr",  interrupts, 0);
    check_eq("arst_busy",  busy, 0);
    check_eq("arst_ready", cmd_ready, 1);
    check_eq("arst_done",  done_pulse, 0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_eq($sformatf("flushed_intr_%0d", c), interrupts, 0);
    end
    single_cmd_test("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
